// File: rtl/g1_pkg.sv
// Shared types and constants for the G1 chain search controller.
package g1_pkg;

  localparam int IDX_W   = 11;
  localparam int TUPLE_W = 104;
  localparam int RULE_W  = 11;
  localparam int HOPS_W  = 5;

  // Chain terminator for next_index and for an empty head.
  localparam logic [IDX_W-1:0] NULL_IDX = 11'h7FF;

  // Field offsets inside the 104-bit tuple {proto,dstPort,srcPort,dstIP,srcIP}.
  localparam int SRC_IP_LSB   = 0;
  localparam int DST_IP_LSB   = 32;
  localparam int SRC_PORT_LSB = 64;
  localparam int DST_PORT_LSB = 80;
  localparam int PROTO_LSB    = 96;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    EVAL  = 3'd3,
    RESP  = 3'd4
  } g1_state_e;

  // Internal hop counter is wider than the reported count; clamp instead of wrapping.
  function automatic logic [HOPS_W-1:0] sat_hops(input logic [IDX_W-1:0] h);
    logic [HOPS_W-1:0] r;
    if (h > IDX_W'((1 << HOPS_W) - 1)) r = '1;
    else                               r = h[HOPS_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/g1_chain_search_ctrl_if.sv
// Request / response / search-unit bundle of the chain search controller.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both 1; the sender holds valid and payload steady until that edge, and the
// receiver may drive ready independently of valid.
interface g1_chain_search_ctrl_if;
  import g1_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [TUPLE_W-1:0]  req_tuple;
  logic [IDX_W-1:0]    req_head;

  logic                resp_valid;
  logic                resp_ready;
  logic                resp_match;
  logic [RULE_W-1:0]   resp_ruleID;
  logic [HOPS_W-1:0]   resp_hops;

  logic [IDX_W-1:0]    tbl_search_index;
  logic [TUPLE_W-1:0]  tbl_tupleData;
  logic                tbl_match;
  logic [RULE_W-1:0]   tbl_ruleID;
  logic [IDX_W-1:0]    tbl_next_index;

  // Environment side: dispatcher plus search unit.
  modport master (
    output req_valid, req_tuple, req_head, resp_ready,
           tbl_match, tbl_ruleID, tbl_next_index,
    input  req_ready, resp_valid, resp_match, resp_ruleID, resp_hops,
           tbl_search_index, tbl_tupleData
  );

  // Controller side.
  modport slave (
    input  req_valid, req_tuple, req_head, resp_ready,
           tbl_match, tbl_ruleID, tbl_next_index,
    output req_ready, resp_valid, resp_match, resp_ruleID, resp_hops,
           tbl_search_index, tbl_tupleData
  );

endinterface

// File: rtl/g1_hop_stats.sv
// Saturating lookup statistics; compiled only when G1_HOP_STATS_EN is defined.
`ifdef G1_HOP_STATS_EN
module g1_hop_stats
  import g1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fire,
  input  logic              hit,
  input  logic [HOPS_W-1:0] hops,
  output logic [31:0]       stat_lookups,
  output logic [31:0]       stat_hits,
  output logic [HOPS_W-1:0] stat_max_hops
);

  // Count completed lookups and hits, track longest chain walked; all saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lookups  <= '0;
      stat_hits     <= '0;
      stat_max_hops <= '0;
    end else if (fire) begin
      if (stat_lookups != '1)         stat_lookups  <= stat_lookups + 32'd1;
      if (hit && (stat_hits != '1))   stat_hits     <= stat_hits + 32'd1;
      if (hops > stat_max_hops)       stat_max_hops <= hops;
    end
  end

endmodule
`endif

// File: rtl/g1_chain_search_ctrl.sv
// Walks one G1 rule chain per lookup: issue index, wait TBL_LAT, evaluate, repeat
// until hit, NULL terminator or MAX_HOPS. Optional statistics under G1_HOP_STATS_EN.
module g1_chain_search_ctrl
  import g1_pkg::*;
#(
  parameter int TBL_LAT  = 2,
  parameter int MAX_HOPS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  g1_chain_search_ctrl_if.slave bus,
  output g1_state_e             dbg_state
`ifdef G1_HOP_STATS_EN
  ,
  output logic [31:0]           stat_lookups,
  output logic [31:0]           stat_hits,
  output logic [HOPS_W-1:0]     stat_max_hops
`endif
);

  localparam int WC_W = (TBL_LAT > 1) ? $clog2(TBL_LAT) : 1;

  g1_state_e           state_q, state_d;
  logic [IDX_W-1:0]    cur_idx_q;
  logic [IDX_W-1:0]    hops_q;
  logic [WC_W-1:0]     wait_cnt_q;
  logic [TUPLE_W-1:0]  tuple_q;
  logic [IDX_W-1:0]    search_idx_q;
  logic                resp_match_q;
  logic [RULE_W-1:0]   resp_rule_q;
  logic [HOPS_W-1:0]   resp_hops_q;
  logic                chain_end;
  logic                resp_fire;

  assign chain_end = (bus.tbl_next_index == NULL_IDX) || (hops_q == IDX_W'(MAX_HOPS));
  assign resp_fire = (state_q == RESP) && bus.resp_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode; tbl_* inputs are only looked at in EVAL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = (bus.req_head == NULL_IDX) ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (wait_cnt_q == '0) state_d = EVAL;
      EVAL:    if (bus.tbl_match || chain_end) state_d = RESP;
               else                            state_d = ISSUE;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    dbg_state      = state_q;
  end

  // Datapath: tuple latch, chain cursor, hop/wait counters, response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_idx_q    <= '0;
      hops_q       <= '0;
      wait_cnt_q   <= '0;
      tuple_q      <= '0;
      search_idx_q <= NULL_IDX;
      resp_match_q <= 1'b0;
      resp_rule_q  <= '0;
      resp_hops_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            tuple_q      <= bus.req_tuple;
            cur_idx_q    <= bus.req_head;
            hops_q       <= '0;
            resp_match_q <= 1'b0;
            resp_rule_q  <= '0;
            resp_hops_q  <= '0;
          end
        end
        ISSUE: begin
          search_idx_q <= cur_idx_q;
          hops_q       <= hops_q + IDX_W'(1);
          wait_cnt_q   <= WC_W'(TBL_LAT - 1);
        end
        WAIT: begin
          if (wait_cnt_q != '0) wait_cnt_q <= wait_cnt_q - WC_W'(1);
        end
        EVAL: begin
          if (bus.tbl_match) begin
            resp_match_q <= 1'b1;
            resp_rule_q  <= bus.tbl_ruleID;
            resp_hops_q  <= sat_hops(hops_q);
          end else if (chain_end) begin
            resp_hops_q  <= sat_hops(hops_q);
          end else begin
            cur_idx_q    <= bus.tbl_next_index;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_match       = resp_match_q;
  assign bus.resp_ruleID      = resp_rule_q;
  assign bus.resp_hops        = resp_hops_q;
  assign bus.tbl_search_index = search_idx_q;
  assign bus.tbl_tupleData    = tuple_q;

`ifdef G1_HOP_STATS_EN
  g1_hop_stats u_stats (
    .clk           (clk),
    .rst           (rst),
    .fire          (resp_fire),
    .hit           (resp_match_q),
    .hops          (resp_hops_q),
    .stat_lookups  (stat_lookups),
    .stat_hits     (stat_hits),
    .stat_max_hops (stat_max_hops)
  );
`else
  logic unused_fire;
  assign unused_fire = resp_fire;
`endif

endmodule

// File: tb/tb_g1_chain_search_ctrl.sv
// Bench for g1_chain_search_ctrl: behavioural search unit (TBL_LAT register
// stages over a rule table), chain-walk reference model, directed and random lookups.
module tb_g1_chain_search_ctrl;
  import g1_pkg::*;

  localparam int TBL_LAT  = 2;
  localparam int MAX_HOPS = 16;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  g1_state_e dbg_state;

  g1_chain_search_ctrl_if bus ();

`ifdef G1_HOP_STATS_EN
  logic [31:0]       stat_lookups;
  logic [31:0]       stat_hits;
  logic [HOPS_W-1:0] stat_max_hops;
`endif

  g1_chain_search_ctrl #(.TBL_LAT(TBL_LAT), .MAX_HOPS(MAX_HOPS)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .dbg_state     (dbg_state)
`ifdef G1_HOP_STATS_EN
    ,
    .stat_lookups  (stat_lookups),
    .stat_hits     (stat_hits),
    .stat_max_hops (stat_max_hops)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- search-unit model ----------------
  logic              tm    [2048];
  logic [RULE_W-1:0] trule [2048];
  logic [IDX_W-1:0]  tnext [2048];
  logic [IDX_W-1:0]  pipe1 = NULL_IDX;
  logic [IDX_W-1:0]  pipe2 = NULL_IDX;

  always @(posedge clk) begin
    pipe1 <= bus.tbl_search_index;
    pipe2 <= pipe1;
  end

  assign bus.tbl_match      = tm[pipe2];
  assign bus.tbl_ruleID     = trule[pipe2];
  assign bus.tbl_next_index = tnext[pipe2];

  // ---------------- scoreboard ----------------
  logic [IDX_W-1:0] exp_q[$];
  logic [IDX_W-1:0] got_q[$];
  logic [IDX_W-1:0] last_issued = NULL_IDX;
  int               tests = 0;
  int               fails = 0;
  g1_state_e        prev_st = IDLE;

  // Record every index the controller presents to the search unit.
  always @(negedge clk) begin
    if (rst) prev_st = IDLE;
    else begin
      if (prev_st == ISSUE) got_q.push_back(bus.tbl_search_index);
      prev_st = dbg_state;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Chain walk straight from the lookup rules.
  function automatic void ref_lookup(input logic [IDX_W-1:0] head, output bit m,
                                     output logic [RULE_W-1:0] rid, output int hops);
    logic [IDX_W-1:0] idx;
    idx  = head;
    m    = 1'b0;
    rid  = '0;
    hops = 0;
    if (head == NULL_IDX) return;
    for (int k = 0; k < MAX_HOPS; k++) begin
      hops++;
      exp_q.push_back(idx);
      if (tm[idx]) begin
        m   = 1'b1;
        rid = trule[idx];
        return;
      end
      if (tnext[idx] == NULL_IDX) return;
      idx = tnext[idx];
    end
  endfunction

  task automatic clear_table();
    for (int i = 0; i < 2048; i++) begin
      tm[i]    = 1'b0;
      trule[i] = '0;
      tnext[i] = NULL_IDX;
    end
  endtask

  task automatic set_entry(input int idx, input logic m, input logic [RULE_W-1:0] rid,
                           input logic [IDX_W-1:0] nxt);
    tm[idx]    = m;
    trule[idx] = rid;
    tnext[idx] = nxt;
  endtask

  // One complete lookup with response back-pressure of `hold` cycles.
  task automatic do_lookup(input logic [IDX_W-1:0] head, input logic [TUPLE_W-1:0] tuple,
                           input int hold, input string tag);
    bit                m;
    logic [RULE_W-1:0] rid;
    int                eh;
    int                lat;
    exp_q.delete();
    got_q.delete();
    ref_lookup(head, m, rid, eh);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_head  = head;
    bus.req_tuple = tuple;
    check({tag, "/req_ready_idle"}, bus.req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_head  = IDX_W'($urandom);
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, lat, eh * (TBL_LAT + 2) + 1);
    check({tag, "/match"}, bus.resp_match, m);
    check({tag, "/ruleID"}, bus.resp_ruleID, rid);
    check({tag, "/hops"}, bus.resp_hops, eh);
    check({tag, "/tuple"}, bus.tbl_tupleData, tuple);
    check({tag, "/req_ready_busy"}, bus.req_ready, 1'b0);
    if (eh == 0) check({tag, "/index_unchanged"}, bus.tbl_search_index, last_issued);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      check({tag, "/hold_valid"}, bus.resp_valid, 1'b1);
      check({tag, "/hold_fields"}, {bus.resp_match, bus.resp_ruleID, bus.resp_hops},
            {m, rid, 5'(eh)});
      check({tag, "/hold_req_ready"}, bus.req_ready, 1'b0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check({tag, "/resp_dropped"}, bus.resp_valid, 1'b0);
    check({tag, "/req_ready_back"}, bus.req_ready, 1'b1);
    check({tag, "/path_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check({tag, "/path_idx"}, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
    if (exp_q.size() > 0) last_issued = exp_q[exp_q.size()-1];
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int               wt;
    logic [TUPLE_W-1:0] tup;
    logic [IDX_W-1:0] hd;
    bus.req_valid  = 1'b0;
    bus.req_head   = NULL_IDX;
    bus.req_tuple  = '0;
    bus.resp_ready = 1'b0;
    clear_table();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset values.
    check("rst/req_ready", bus.req_ready, 1'b1);
    check("rst/resp_valid", bus.resp_valid, 1'b0);
    check("rst/resp_fields", {bus.resp_match, bus.resp_ruleID, bus.resp_hops}, '0);
    check("rst/search_index", bus.tbl_search_index, NULL_IDX);
    check("rst/tupleData", bus.tbl_tupleData, '0);
    check("rst/state", dbg_state, IDLE);

    // Single-entry hit.
    set_entry(5, 1'b1, 11'h12, NULL_IDX);
    do_lookup(11'd5, {$urandom, $urandom, $urandom, $urandom}, 0, "hit1");

    // Empty head while the search unit still shows the previous hit.
    do_lookup(NULL_IDX, {$urandom, $urandom, $urandom, $urandom}, 2, "nullhead");

    // Three-entry chain, hit on the last one.
    clear_table();
    set_entry(5, 1'b0, 11'h01, 11'd9);
    set_entry(9, 1'b0, 11'h02, 11'd3);
    set_entry(3, 1'b1, 11'h40, 11'd6);
    do_lookup(11'd5, {$urandom, $urandom, $urandom, $urandom}, 1, "chain3");

    // Chain ending in NULL without a hit.
    set_entry(9, 1'b0, 11'h02, NULL_IDX);
    do_lookup(11'd5, {$urandom, $urandom, $urandom, $urandom}, 0, "chainmiss");

    // Self loop bounded by the hop limit, long back-pressure.
    set_entry(7, 1'b0, 11'h33, 11'd7);
    do_lookup(11'd7, {$urandom, $urandom, $urandom, $urandom}, 10, "selfloop");

    // Reset in the middle of the second hop.
    set_entry(9, 1'b0, 11'h02, 11'd3);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_head  = 11'd5;
    bus.req_tuple = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    wt = 0;
    while (!(dbg_state == WAIT && bus.tbl_search_index === 11'd9) && wt < 100) begin
      @(negedge clk);
      wt++;
    end
    check("midrst/reached_hop2", wt < 100, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst/req_ready", bus.req_ready, 1'b1);
    check("midrst/resp_valid", bus.resp_valid, 1'b0);
    check("midrst/search_index", bus.tbl_search_index, NULL_IDX);
    check("midrst/tupleData", bus.tbl_tupleData, '0);
    last_issued = NULL_IDX;
    do_lookup(11'd5, {$urandom, $urandom, $urandom, $urandom}, 0, "postrst");

    // Random tables and heads, including loops and empty heads.
    for (int r = 0; r < 12; r++) begin
      clear_table();
      for (int i = 0; i < 32; i++)
        set_entry(i, ($urandom_range(0, 6) == 0),
                  IDX_W'($urandom_range(1, 2046)),
                  ($urandom_range(0, 5) == 0) ? NULL_IDX : IDX_W'($urandom_range(0, 31)));
      hd  = ($urandom_range(0, 7) == 0) ? NULL_IDX : IDX_W'($urandom_range(0, 31));
      tup = {$urandom, $urandom, $urandom, $urandom};
      do_lookup(hd, tup, $urandom_range(0, 3), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
